// File: rtl/twiddle_seq_ctrl.sv
// twiddle_seq_ctrl
// Sequences one in-place radix-2 DIT FFT pass over N = 2^N_LOG2 points
// (bit-reversed input). It walks stages, twiddle positions and groups, and
// hands operand addresses to the butterfly datapath over valid/ready. The
// twiddle ROM is read and the holding register (C, C+S, C-S) is reloaded
// only when the twiddle index k changes.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_reset     asynchronous active-high reset, forces IDLE
//   i_start     one-cycle request to run a full pass (only seen in IDLE)
//   i_bf_ready  butterfly datapath accepts the current operands
//   o_tw_addr   twiddle ROM index k
//   o_c_we      write enable of the twiddle holding register
//   o_bf_valid  o_addr_a/o_addr_b/o_stage are valid
//   o_addr_a    upper operand address
//   o_addr_b    lower operand address (o_addr_a + span)
//   o_stage     current stage
//   o_busy      high from the cycle after start accept through DONE
//   o_done      one-cycle pulse at end of pass
//
// state  | meaning
// IDLE   | waiting for i_start
// FETCH  | o_tw_addr presented to the ROM for ROM_LAT cycles
// LOAD   | o_c_we pulse, ROM data captured into the holding register
// ISSUE  | butterfly operands offered with o_bf_valid
// DONE   | o_done pulse, back to IDLE
module twiddle_seq_ctrl #(
  parameter int N_LOG2  = 4,
  parameter int ROM_LAT = 1,
  parameter int STAGE_W = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_bf_ready,
  output logic [N_LOG2-2:0]   o_tw_addr,
  output logic                o_c_we,
  output logic                o_bf_valid,
  output logic [N_LOG2-1:0]   o_addr_a,
  output logic [N_LOG2-1:0]   o_addr_b,
  output logic [STAGE_W-1:0]  o_stage,
  output logic                o_busy,
  output logic                o_done
);

  localparam int K_W   = N_LOG2 - 1;
  localparam int LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_DONE} state_t;

  state_t             r_state;
  logic [STAGE_W-1:0] r_stage;
  logic [K_W-1:0]     r_pos;
  logic [K_W-1:0]     r_grp;
  logic [LAT_W-1:0]   r_lat;
  logic [K_W-1:0]     r_loaded_k;
  logic               r_loaded_valid;

  logic [STAGE_W-1:0] w_nxt_stage;
  logic [K_W-1:0]     w_nxt_pos;
  logic [K_W-1:0]     w_nxt_grp;
  logic [K_W-1:0]     w_span_m1;
  logic [K_W-1:0]     w_grp_m1;
  logic [K_W-1:0]     w_nxt_k;
  logic [N_LOG2-1:0]  w_nxt_a;
  logic [N_LOG2-1:0]  w_nxt_b;
  logic               w_last;

  // k = pos << (N_LOG2-1-s)
  function automatic logic [K_W-1:0] f_k(input logic [STAGE_W-1:0] s,
                                         input logic [K_W-1:0] p);
    return K_W'(int'(p) << (N_LOG2 - 1 - int'(s)));
  endfunction

  // addr_a = grp*2*span + pos
  function automatic logic [N_LOG2-1:0] f_addr_a(input logic [STAGE_W-1:0] s,
                                                 input logic [K_W-1:0] g,
                                                 input logic [K_W-1:0] p);
    return N_LOG2'((int'(g) << (int'(s) + 1)) + int'(p));
  endfunction

  assign o_stage = r_stage;

  // Next iteration point: groups innermost, then positions, then stages.
  always_comb begin
    w_span_m1   = K_W'((1 << int'(r_stage)) - 1);
    w_grp_m1    = K_W'(((1 << K_W) >> int'(r_stage)) - 1);
    w_nxt_stage = r_stage;
    w_nxt_pos   = r_pos;
    w_nxt_grp   = r_grp;
    w_last      = 1'b0;
    if (r_grp != w_grp_m1) begin
      w_nxt_grp = r_grp + 1'b1;
    end else begin
      w_nxt_grp = '0;
      if (r_pos != w_span_m1) begin
        w_nxt_pos = r_pos + 1'b1;
      end else begin
        w_nxt_pos = '0;
        if (r_stage == STAGE_W'(N_LOG2 - 1)) w_last = 1'b1;
        else                                 w_nxt_stage = r_stage + 1'b1;
      end
    end
    w_nxt_k = f_k(w_nxt_stage, w_nxt_pos);
    w_nxt_a = f_addr_a(w_nxt_stage, w_nxt_grp, w_nxt_pos);
    w_nxt_b = w_nxt_a + N_LOG2'(1 << int'(w_nxt_stage));
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_stage        <= '0;
      r_pos          <= '0;
      r_grp          <= '0;
      r_lat          <= '0;
      r_loaded_k     <= '0;
      r_loaded_valid <= 1'b0;
      o_tw_addr      <= '0;
      o_c_we         <= 1'b0;
      o_bf_valid     <= 1'b0;
      o_addr_a       <= '0;
      o_addr_b       <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state        <= S_FETCH;
            r_stage        <= '0;
            r_pos          <= '0;
            r_grp          <= '0;
            r_lat          <= LAT_W'(ROM_LAT - 1);
            r_loaded_valid <= 1'b0;
            o_tw_addr      <= '0;
            o_addr_a       <= '0;
            o_addr_b       <= N_LOG2'(1);
            o_busy         <= 1'b1;
          end
        end
        S_FETCH: begin
          if (r_lat == '0) begin
            r_state <= S_LOAD;
            o_c_we  <= 1'b1;
          end else begin
            r_lat <= r_lat - 1'b1;
          end
        end
        S_LOAD: begin
          o_c_we         <= 1'b0;
          r_loaded_k     <= o_tw_addr;
          r_loaded_valid <= 1'b1;
          o_bf_valid     <= 1'b1;
          r_state        <= S_ISSUE;
        end
        S_ISSUE: begin
          if (i_bf_ready) begin
            if (w_last) begin
              r_state    <= S_DONE;
              o_bf_valid <= 1'b0;
              o_done     <= 1'b1;
            end else begin
              r_stage  <= w_nxt_stage;
              r_pos    <= w_nxt_pos;
              r_grp    <= w_nxt_grp;
              o_addr_a <= w_nxt_a;
              o_addr_b <= w_nxt_b;
              // Same twiddle already in the holding register: keep issuing.
              if (!(r_loaded_valid && (w_nxt_k == r_loaded_k))) begin
                r_state    <= S_FETCH;
                o_bf_valid <= 1'b0;
                o_tw_addr  <= w_nxt_k;
                r_lat      <= LAT_W'(ROM_LAT - 1);
              end
            end
          end
        end
        S_DONE: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
